display_page_scheduler: RTL and testbench

DISPLAY_PAGE_SCHEDULER -- requirements
Module: display_page_scheduler

---
 rtl/display_page_scheduler.sv | 151 +++++++++++++++
 tb/tb_display_page_scheduler.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/display_page_scheduler.sv
// display_page_scheduler - debounced page button, periodic display value latch, stretched beat LED.
module display_page_scheduler #(
  parameter int REFRESH_DIV     = 500000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BEAT_STRETCH    = 5000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_n,
  input  logic [15:0] bpm_in,
  input  logic [15:0] strength_in,
  input  logic [31:0] flux_in,
  input  logic        beat_pulse,
  output logic [15:0] value_out,
  output logic [1:0]  page_out,
  output logic        value_update,
  output logic        beat_led
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int BW = $clog2(BEAT_STRETCH + 1);
  localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BW-1:0] BEAT_LOAD = BW'(BEAT_STRETCH);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} db_state_t;

  db_state_t      state, state_next;
  logic           key_meta, key_s;
  logic [DW-1:0]  db_cnt;
  logic           db_clr, press;
  logic [RW-1:0]  ref_cnt;
  logic           tick;
  logic [BW-1:0]  beat_cnt;
  logic [1:0]     page_next;
  logic [15:0]    flux_sat, src_cur, src_new;

  function automatic logic [15:0] page_src(input logic [1:0] p, input logic [15:0] bpm,
                                           input logic [15:0] str, input logic [15:0] flx);
    case (p)
      2'd0:    page_src = bpm;
      2'd1:    page_src = str;
      default: page_src = flx;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      key_meta <= 1'b1;
      key_s    <= 1'b1;
    end else begin
      key_meta <= key_n;
      key_s    <= key_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      db_cnt <= '0;
    end else begin
      state <= state_next;
      if (db_clr)
        db_cnt <= '0;
      else if ((state == PRESS_WAIT || state == RELEASE_WAIT) && db_cnt != DB_LAST)
        db_cnt <= db_cnt + DW'(1);
    end
  end

  always_comb begin
    state_next = state;
    db_clr     = 1'b0;
    press      = 1'b0;
    case (state)
      IDLE: begin
        if (!key_s) begin
          state_next = PRESS_WAIT;
          db_clr     = 1'b1;
        end
      end
      PRESS_WAIT: begin
        if (key_s) begin
          state_next = IDLE;
        end else if (db_cnt == DB_LAST) begin
          state_next = HELD;
          press      = 1'b1;
        end
      end
      HELD: begin
        if (key_s) begin
          state_next = RELEASE_WAIT;
          db_clr     = 1'b1;
        end
      end
      RELEASE_WAIT: begin
        if (!key_s)
          state_next = HELD;
        else if (db_cnt == DB_LAST)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Flux wider than 16 bits pins the display at all-ones rather than showing a wrapped value.
  assign flux_sat  = (flux_in[31:16] == 16'd0) ? flux_in[15:0] : 16'hFFFF;
  assign page_next = (page_out == 2'd2) ? 2'd0 : page_out + 2'd1;
  assign src_cur   = page_src(page_out, bpm_in, strength_in, flux_sat);
  assign src_new   = page_src(page_next, bpm_in, strength_in, flux_sat);
  assign tick      = (ref_cnt == REF_LAST);

  // A press overrides a coincident tick: the new page is shown immediately and refresh restarts.
  always_ff @(posedge clk) begin
    if (reset) begin
      page_out     <= 2'd0;
      value_out    <= 16'd0;
      value_update <= 1'b0;
      ref_cnt      <= '0;
    end else begin
      value_update <= 1'b0;
      if (press) begin
        page_out     <= page_next;
        value_out    <= src_new;
        value_update <= 1'b1;
        ref_cnt      <= '0;
      end else begin
        ref_cnt <= tick ? '0 : ref_cnt + RW'(1);
        if (tick) begin
          value_out    <= src_cur;
          value_update <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt <= '0;
      beat_led <= 1'b0;
    end else if (beat_pulse) begin
      beat_cnt <= BEAT_LOAD;
      beat_led <= 1'b1;
    end else if (beat_cnt != '0) begin
      beat_cnt <= beat_cnt - BW'(1);
      if (beat_cnt == BW'(1))
        beat_led <= 1'b0;
    end
  end

endmodule

// File: tb/tb_display_page_scheduler.sv
// tb/tb_display_page_scheduler.sv - randomized bench with run-length reference model for display_page_scheduler.
module tb_display_page_scheduler;
  localparam int R  = 10;
  localparam int D  = 4;
  localparam int BS = 6;

  logic        clk = 1'b0;
  logic        reset, key_n, beat_pulse;
  logic [15:0] bpm_in, strength_in;
  logic [31:0] flux_in;
  logic [15:0] value_out;
  logic [1:0]  page_out;
  logic        value_update, beat_led;

  display_page_scheduler #(.REFRESH_DIV(R), .DEBOUNCE_CYCLES(D), .BEAT_STRETCH(BS)) dut (
    .clk(clk), .reset(reset), .key_n(key_n), .bpm_in(bpm_in), .strength_in(strength_in),
    .flux_in(flux_in), .beat_pulse(beat_pulse), .value_out(value_out), .page_out(page_out),
    .value_update(value_update), .beat_led(beat_led)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: key is judged by lengths of stable runs, refresh by cycles since restart,
  // the LED by distance from the most recent beat.
  logic        m_s1, m_s2, held;
  int          low_run, high_run, since, cyc, last_beat;
  bit          has_beat;
  logic [1:0]  exp_page;
  logic [15:0] exp_val;
  logic        exp_upd, exp_led;

  function automatic logic [15:0] model_src(input logic [1:0] p);
    if (p == 2'd0) return bpm_in;
    if (p == 2'd1) return strength_in;
    return (flux_in > 32'h0000_FFFF) ? 16'hFFFF : flux_in[15:0];
  endfunction

  always @(posedge clk) begin
    logic ks;
    bit   pr;
    cyc++;
    if (reset) begin
      m_s1 = 1'b1; m_s2 = 1'b1; held = 1'b0;
      low_run = 0; high_run = 0; since = 0; has_beat = 0;
      exp_page = 2'd0; exp_val = 16'd0; exp_upd = 1'b0;
    end else begin
      ks = m_s2;
      m_s2 = m_s1;
      m_s1 = key_n;
      if (ks == 1'b0) begin low_run++; high_run = 0; end
      else begin high_run++; low_run = 0; end
      pr = !held && low_run == D + 1;
      if (pr) held = 1'b1;
      else if (held && high_run == D + 1) held = 1'b0;
      exp_upd = 1'b0;
      if (pr) begin
        exp_page = (exp_page + 2'd1) % 3;
        exp_val  = model_src(exp_page);
        exp_upd  = 1'b1;
        since    = 0;
      end else begin
        if (since % R == R - 1) begin
          exp_val = model_src(exp_page);
          exp_upd = 1'b1;
        end
        since++;
      end
      if (beat_pulse) begin has_beat = 1; last_beat = cyc - 1; end
    end
    exp_led = has_beat && (cyc - last_beat) <= BS;
  end

  int upd_count;

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      check("page", page_out, exp_page);
      check("value", value_out, exp_val);
      check("update", value_update, exp_upd);
      check("beat_led", beat_led, exp_led);
      if (value_update) upd_count++;
    end
  endtask

  task automatic press(input int low_cycles);
    key_n = 1'b0;
    run(low_cycles);
    key_n = 1'b1;
    run(2 * D + 6);
  endtask

  int key_left;

  initial begin
    cyc = 0;
    reset = 1'b1; key_n = 1'b1; beat_pulse = 1'b0;
    bpm_in = 16'd120; strength_in = 16'd77; flux_in = 32'd0;
    run(3);
    check("rst_value", value_out, 16'd0);
    check("rst_page", page_out, 2'd0);
    check("rst_update", value_update, 1'b0);
    check("rst_led", beat_led, 1'b0);
    reset = 1'b0;

    upd_count = 0;
    run(40);
    check("bpm_update_count", upd_count, 4);
    check("bpm_value", value_out, 16'd120);

    press(3);
    check("short_press_page", page_out, 2'd0);
    press(20);
    check("press1_page", page_out, 2'd1);
    check("press1_value", value_out, 16'd77);

    flux_in = 32'h0001_0000;
    press(20);
    check("press2_page", page_out, 2'd2);
    check("flux_sat", value_out, 16'hFFFF);
    flux_in = 32'h0000_1234;
    run(R + 1);
    check("flux_plain", value_out, 16'h1234);
    press(20);
    check("press3_page", page_out, 2'd0);

    beat_pulse = 1'b1; run(1); beat_pulse = 1'b0; run(3);
    beat_pulse = 1'b1; run(1); beat_pulse = 1'b0; run(12);
    check("beat_off", beat_led, 1'b0);

    press(20);
    key_n = 1'b0;
    run(4);
    beat_pulse = 1'b1; run(1); beat_pulse = 1'b0;
    reset = 1'b1;
    run(2);
    check("midpress_rst_page", page_out, 2'd0);
    check("midpress_rst_led", beat_led, 1'b0);
    reset = 1'b0;
    run(D + 2);
    check("no_early_press", page_out, 2'd0);
    run(10);
    check("post_rst_press", page_out, 2'd1);
    key_n = 1'b1;
    run(2 * D + 4);

    key_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (key_left == 0) begin
        key_n = ~key_n;
        key_left = $urandom_range(1, 14);
      end
      key_left--;
      beat_pulse = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) bpm_in = 16'($urandom);
      if ($urandom_range(0, 7) == 0) strength_in = 16'($urandom);
      if ($urandom_range(0, 7) == 0)
        flux_in = ($urandom_range(0, 1) == 0) ? {16'd0, 16'($urandom)} : 32'($urandom);
      reset = ($urandom_range(0, 599) == 0);
      run(1);
    end
    reset = 1'b0; beat_pulse = 1'b0;
    run(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
